// File: rtl/display_source_scheduler_if.sv
// Bundles the source request/value bus and the digit output bus of the display scheduler.
// The exit pulse is named grant_release because "release" is a reserved word in SystemVerilog.
interface display_source_scheduler_if;
  logic [3:0]  req;
  logic [31:0] values;
  logic [3:0]  grant;
  logic [3:0]  digit;
  logic [1:0]  digit_place;
  logic        blank;
  logic        grant_release;

  modport master (output req, values, input grant, digit, digit_place, blank, grant_release);
  modport slave  (input req, values, output grant, digit, digit_place, blank, grant_release);
endinterface

// File: rtl/display_source_scheduler.sv
// Round-robin sharing of one 3-digit display between four 8-bit sources:
// grant, double-dabble convert, then scan digits with leading-zero blanking.
module display_source_scheduler #(
  parameter int SCAN_POW2  = 3,
  parameter int DWELL_POW2 = 10
) (
  input logic                       clock,
  input logic                       reset_n,
  display_source_scheduler_if.slave bus
);

  // IDLE: wait for a request | CONVERT: 8 shift-add-3 steps | SHOW: scan places for the dwell period
  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  state_t                state, state_nxt;
  logic [3:0]            grant, grant_nxt;
  logic [1:0]            ptr, ptr_nxt;
  logic [1:0]            winner, winner_nxt;
  logic [1:0]            place, place_nxt;
  logic [1:0]            pick;
  logic [7:0]            shift_reg, shift_nxt;
  logic [11:0]           bcd, bcd_nxt;
  logic [11:0]           adj;
  logic [19:0]           shifted;
  logic [2:0]            step, step_nxt;
  logic [SCAN_POW2-1:0]  scan_cnt, scan_nxt;
  logic [DWELL_POW2-1:0] dwell_cnt, dwell_nxt;
  logic                  released, released_nxt;
  logic                  abort;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Lowest offset from the pointer wins, so scan offsets from high to low.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
  end

  assign adj     = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign shifted = {adj, shift_reg} << 1;
  assign abort   = !bus.req[winner];

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    winner_nxt   = winner;
    place_nxt    = place;
    shift_nxt    = shift_reg;
    bcd_nxt      = bcd;
    step_nxt     = step;
    scan_nxt     = scan_cnt;
    dwell_nxt    = dwell_cnt;
    released_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          winner_nxt = pick;
          grant_nxt  = 4'b0001 << pick;
          shift_nxt  = bus.values[8*pick +: 8];
          bcd_nxt    = '0;
          step_nxt   = '0;
          state_nxt  = CONVERT;
        end
      end
      CONVERT: begin
        if (!abort) begin
          bcd_nxt   = shifted[19:8];
          shift_nxt = shifted[7:0];
          step_nxt  = step + 3'd1;
          if (step == 3'd7) begin
            state_nxt = SHOW;
            scan_nxt  = '0;
            dwell_nxt = '0;
            place_nxt = 2'd2;
          end
        end
      end
      SHOW: begin
        if (!abort && dwell_cnt != '1) begin
          dwell_nxt = dwell_cnt + 1'b1;
          scan_nxt  = scan_cnt + 1'b1;
          if (scan_cnt == '1) place_nxt = (place == 2'd0) ? 2'd2 : place - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Dwell expiry and abort share one exit path.
    if ((state == CONVERT && abort) || (state == SHOW && (abort || dwell_cnt == '1))) begin
      state_nxt    = IDLE;
      grant_nxt    = '0;
      ptr_nxt      = winner + 2'd1;
      place_nxt    = 2'd2;
      released_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      winner    <= '0;
      place     <= 2'd2;
      shift_reg <= '0;
      bcd       <= '0;
      step      <= '0;
      scan_cnt  <= '0;
      dwell_cnt <= '0;
      released  <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      winner    <= winner_nxt;
      place     <= place_nxt;
      shift_reg <= shift_nxt;
      bcd       <= bcd_nxt;
      step      <= step_nxt;
      scan_cnt  <= scan_nxt;
      dwell_cnt <= dwell_nxt;
      released  <= released_nxt;
    end
  end

  assign bus.grant         = grant;
  assign bus.digit_place   = place;
  assign bus.grant_release = released;

  always_comb begin
    bus.digit = 4'hF;
    bus.blank = 1'b1;
    if (state == SHOW) begin
      case (place)
        2'd2: begin
          bus.digit = bcd[11:8];
          bus.blank = (bcd[11:8] == 4'd0);
        end
        2'd1: begin
          bus.digit = bcd[7:4];
          bus.blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        end
        default: begin
          bus.digit = bcd[3:0];
          bus.blank = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler: conversions, blanking, round-robin, abort, reset.
module tb_display_source_scheduler;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  display_source_scheduler_if bus ();

  display_source_scheduler #(.SCAN_POW2(3), .DWELL_POW2(10)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input logic [3:0] expg, input int budget);
    int n = 0;
    while (bus.grant == 4'd0 && n < budget) begin
      tick();
      n++;
    end
    check("grant", 32'(bus.grant), 32'(expg));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_digit"}, 32'(bus.digit), 32'hF);
    check({tag, "_place"}, 32'(bus.digit_place), 2);
    check({tag, "_blank"}, 32'(bus.blank), 1);
  endtask

  // Grants one source, corrupts its value after the grant edge, checks all three places, then aborts.
  task automatic show_case(input logic [1:0] src, input logic [7:0] v,
                           input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic bh, input logic bt);
    bus.values[8*src +: 8] = v;
    bus.req = 4'b0001 << src;
    wait_grant(4'b0001 << src, 4);
    check_idle_outputs("convert");
    bus.values[8*src +: 8] = v ^ 8'hA5;
    tick(8);
    check("hund_place", 32'(bus.digit_place), 2);
    check("hund_digit", 32'(bus.digit), 32'(h));
    check("hund_blank", 32'(bus.blank), 32'(bh));
    bus.values[8*src +: 8] = ~v;
    tick(8);
    check("tens_place", 32'(bus.digit_place), 1);
    check("tens_digit", 32'(bus.digit), 32'(t));
    check("tens_blank", 32'(bus.blank), 32'(bt));
    tick(8);
    check("ones_place", 32'(bus.digit_place), 0);
    check("ones_digit", 32'(bus.digit), 32'(o));
    check("ones_blank", 32'(bus.blank), 0);
    bus.req = 4'b0000;
    tick();
    check("abort_grant", 32'(bus.grant), 0);
    check("abort_release", 32'(bus.grant_release), 1);
    tick();
    check("abort_release_end", 32'(bus.grant_release), 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.req    = 4'b0000;
    bus.values = 32'h0;
    tick(2);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_release", 32'(bus.grant_release), 0);
    check_idle_outputs("rst");
    reset_n = 1'b1;
    tick();

    // Single grant of value 7 with full dwell.
    bus.values[7:0] = 8'd7;
    bus.req = 4'b0001;
    tick();
    check("single_grant", 32'(bus.grant), 32'h1);
    check_idle_outputs("single_convert");
    tick(7);
    check("single_still_convert", 32'(bus.digit), 32'hF);
    tick();
    check("single_h_place", 32'(bus.digit_place), 2);
    check("single_h_blank", 32'(bus.blank), 1);
    tick(7);
    check("single_h_hold", 32'(bus.digit_place), 2);
    tick();
    check("single_t_place", 32'(bus.digit_place), 1);
    check("single_t_blank", 32'(bus.blank), 1);
    tick(8);
    check("single_o_place", 32'(bus.digit_place), 0);
    check("single_o_digit", 32'(bus.digit), 7);
    check("single_o_blank", 32'(bus.blank), 0);
    tick(8);
    check("single_wrap_place", 32'(bus.digit_place), 2);
    tick(999);
    check("dwell_last_grant", 32'(bus.grant), 32'h1);
    check("dwell_last_release", 32'(bus.grant_release), 0);
    tick();
    check("dwell_end_grant", 32'(bus.grant), 0);
    check("dwell_end_release", 32'(bus.grant_release), 1);
    check("dwell_end_digit", 32'(bus.digit), 32'hF);
    bus.req = 4'b0000;
    tick();
    check("dwell_idle_release", 32'(bus.grant_release), 0);
    check("dwell_idle_grant", 32'(bus.grant), 0);

    // Conversions; source order leaves the pointer at 0 afterwards.
    show_case(2'd1, 8'd255, 4'd2, 4'd5, 4'd5, 1'b0, 1'b0);
    show_case(2'd2, 8'd0,   4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    show_case(2'd0, 8'd40,  4'd0, 4'd4, 4'd0, 1'b1, 1'b0);
    show_case(2'd3, 8'd100, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);

    // Round-robin with all sources requesting.
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
      tick(1032);
      check("rr_gap_grant", 32'(bus.grant), 0);
      check("rr_gap_release", 32'(bus.grant_release), 1);
      if (k == 4) bus.req = 4'b0000;
      tick();
    end
    check("rr_idle", 32'(bus.grant), 0);

    // Abort mid-SHOW with source 2 pending; pointer is 1 here.
    bus.req = 4'b0010;
    wait_grant(4'b0010, 4);
    tick(28);
    bus.req = 4'b0100;
    tick();
    check("abort_show_grant", 32'(bus.grant), 0);
    check("abort_show_release", 32'(bus.grant_release), 1);
    tick();
    check("pending_grant", 32'(bus.grant), 32'h4);
    check("pending_release", 32'(bus.grant_release), 0);

    // Abort source 2 during CONVERT so the pointer moves to 3, then grant source 3.
    tick(4);
    bus.req = 4'b0000;
    tick();
    check("abort_conv_grant", 32'(bus.grant), 0);
    check("abort_conv_release", 32'(bus.grant_release), 1);
    tick();
    bus.req = 4'b1000;
    wait_grant(4'b1000, 4);
    tick(18);

    // Reset mid-SHOW: pointer returns to 0, so source 2 beats source 3.
    bus.req = 4'b1100;
    reset_n = 1'b0;
    tick();
    check("midrst_grant", 32'(bus.grant), 0);
    check("midrst_release", 32'(bus.grant_release), 0);
    check_idle_outputs("midrst");
    reset_n = 1'b1;
    tick();
    check("post_rst_grant", 32'(bus.grant), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/display_source_scheduler.md
# display_source_scheduler

Time-shares the board's single 3-digit decimal display between four 8-bit value sources. It grants one requesting source at a time in round-robin order, latches that source's value, and converts it serially to BCD with an 8-cycle shift-add-3 sequence. It then scans hundreds/tens/ones with leading-zero blanking for a fixed dwell period before re-arbitrating. It sits between the status/counter producers and the seven-segment driver.

## Interface

- SCAN_POW2, 3: each digit place is held for 2^SCAN_POW2 clocks.
- DWELL_POW2, 10: SHOW state lasts 2^DWELL_POW2 clocks; legal only if DWELL_POW2 >= SCAN_POW2 + 2.
- clock  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- req  input  4  per-source request; level, held while the source wants display time.
- values  input  32  source values; source i on values[8i+7:8i].
- grant  output  4  one-hot registered grant; 0 when no source is granted.
- digit  output  4  BCD nibble for the current place; 4'hF when not in SHOW.
- digit_place  output  2  2=hundreds, 1=tens, 0=ones.
- blank  output  1  1 = segment driver must darken the current place.
- release  output  1  one-clock pulse on the cycle after a grant ends (dwell expiry or abort).

## Operation

- States: IDLE, CONVERT, SHOW.
- Reset (any state, any cycle): state IDLE, grant 0, digit 4'hF, digit_place 2, blank 1, release 0, round-robin pointer 0, all counters 0, BCD register 0.
- IDLE: digit 4'hF, digit_place 2, blank 1. On a clock edge where req != 0:
  - winner = first set req bit searching upward from pointer, wrapping 3->0;
  - capture values[winner] into the shift register; set grant to one-hot(winner); state <= CONVERT; clear the 3-bit step counter.
- CONVERT: 8 steps, one per clock, with the step counter at 0..7. Each step:
  - add 3 to every BCD nibble >= 5;
  - shift {bcd[11:0], shift_reg[7:0]} left by 1.
  - The step-7 edge moves to SHOW with the final BCD registered. It also clears the scan and dwell counters and sets digit_place to 2.
  - Outputs remain as in IDLE, apart from grant.
- SHOW:
  - digit = hundreds, tens or ones nibble selected by digit_place.
  - digit_place sequence: 2,1,0,2,... Each place is held 2^SCAN_POW2 clocks.
  - Blanking:
    - place 2 is blanked when hundreds == 0;
    - place 1 is blanked when hundreds == 0 and tens == 0;
    - place 0 is never blanked.
  - The dwell counter counts every SHOW clock. At terminal count, state <= IDLE, grant <= 0, pointer <= winner+1 mod 4, and release pulses the next cycle.
- Abort: if req[winner] is sampled low in CONVERT or SHOW, the next edge takes the same exit as dwell expiry (IDLE, grant 0, pointer advance, release pulse).
- values are sampled only on the grant edge. Later changes to values, including the granted source's value, do not affect the current grant.
- Requests arriving during CONVERT/SHOW wait; there is no preemption.
- Conversion range: 0..255 maps to hundreds 0..2; tens and ones 0..9. The BCD register is 12 bits, with no overflow possible.

## Timing

- Edge E0 samples req != 0 in IDLE. grant is valid from E0, and CONVERT occupies the 8 cycles after E0. SHOW begins after E8, so the first valid digit (place 2) appears 8 clocks after grant.
- Uninterrupted grant: 8 + 2^DWELL_POW2 clocks. It is followed by at least one IDLE cycle, during which grant is 0 and release is 1.
- Back-to-back requests: the next grant edge is the first edge after the release cycle. The minimum inter-grant gap is 1 clock with grant 0.
- Abort: grant falls one edge after req[winner] is sampled low.
- All outputs are registered or decoded only from registered state and the BCD register. There is no combinational path from req/values to any output.

## Test plan

- Reset, then single grant: req=0001, values[7:0]=7. grant=0001 one cycle later; SHOW after 8 clocks. Place 2 blank, place 1 blank, place 0 digit 7 unblanked. Each place held 8 clocks. release pulses after 8+1024 clocks.
- Conversions: value 255 -> 2,5,5, none blanked; value 0 -> places 2,1 blank, place 0 digit 0; value 100 -> 1,0,0, none blanked; value 40 -> place 2 blank, then 4,0.
- Round-robin: req=1111 held. Grant order 0001,0010,0100,1000,0001, with a 1-clock grant=0 gap between each.
- Abort: drop req[winner] mid-SHOW. grant=0 on the next edge; release pulses; a pending req=0100 is granted on the following edge.
- Value stability: change values for the granted source during CONVERT and SHOW. Displayed digits stay those of the value captured at grant.
- Reset mid-SHOW: assert reset_n=0 for 1 clock. All outputs take their reset values on that edge; the pointer returns to 0, so with req=1100 held source 2 is granted first.
